// File: rtl/regfile_master_pkg.sv
// Shared opcodes, state encoding and default widths for the regfile master and its bench.
// The VERIFY state only exists when REGFILE_WR_VERIFY_EN is defined.
package regfile_master_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;

    localparam logic [1:0] OP_RD  = 2'b00;
    localparam logic [1:0] OP_WR  = 2'b01;
    localparam logic [1:0] OP_CLR = 2'b10;
    localparam logic [1:0] OP_RSV = 2'b11;

    typedef enum logic [2:0] {
        ST_CLEAR  = 3'd0,
        ST_IDLE   = 3'd1,
        ST_WRITE  = 3'd2,
        ST_READ   = 3'd3,
`ifdef REGFILE_WR_VERIFY_EN
        ST_RESP   = 3'd4,
        ST_VERIFY = 3'd5
`else
        ST_RESP   = 3'd4
`endif
    } state_t;

endpackage

// File: rtl/regfile_master.sv
// Command sequencer for the single-port regfile: clear sweep after reset, read/write/clear commands.
// Optional write read-back check under REGFILE_WR_VERIFY_EN (sticky wr_err); wr_err is 0 otherwise.
module regfile_master
    import regfile_master_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              busy,
    output logic              wr_err,
    output logic              rf_we_,
    output logic [ADDR_W-1:0] rf_addr,
    output logic [DATA_W-1:0] rf_din,
    input  logic [DATA_W-1:0] rf_dout
);

    localparam logic [ADDR_W-1:0] LAST_ADDR = {ADDR_W{1'b1}};

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] clr_ptr_q, clr_ptr_d;
    logic              rf_we_q, rf_we_d;
    logic [ADDR_W-1:0] rf_addr_q, rf_addr_d;
    logic [DATA_W-1:0] rf_din_q, rf_din_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
`ifdef REGFILE_WR_VERIFY_EN
    logic              wr_err_q, wr_err_d;
`endif

    always_comb begin
        state_d     = state_q;
        clr_ptr_d   = clr_ptr_q;
        rf_we_d     = rf_we_q;
        rf_addr_d   = rf_addr_q;
        rf_din_d    = rf_din_q;
        rsp_valid_d = rsp_valid_q;
        rsp_rdata_d = rsp_rdata_q;
`ifdef REGFILE_WR_VERIFY_EN
        wr_err_d    = wr_err_q;
`endif
        case (state_q)
            ST_CLEAR: begin
                // rf_we_ still high means the sweep has not issued address 0 yet
                if (rf_we_q) begin
                    rf_we_d   = 1'b0;
                    rf_addr_d = clr_ptr_q;
                    rf_din_d  = '0;
                end else if (clr_ptr_q == LAST_ADDR) begin
                    rf_we_d = 1'b1;
                    state_d = ST_IDLE;
                end else begin
                    clr_ptr_d = clr_ptr_q + 1'b1;
                    rf_addr_d = clr_ptr_q + 1'b1;
                    rf_din_d  = '0;
                end
            end
            ST_IDLE: begin
                if (cmd_valid) begin
                    case (cmd_op)
                        OP_WR: begin
                            state_d   = ST_WRITE;
                            rf_we_d   = 1'b0;
                            rf_addr_d = cmd_addr;
                            rf_din_d  = cmd_wdata;
                        end
                        OP_RD: begin
                            state_d   = ST_READ;
                            rf_we_d   = 1'b1;
                            rf_addr_d = cmd_addr;
                        end
                        OP_CLR: begin
                            state_d   = ST_CLEAR;
                            clr_ptr_d = '0;
                            rf_we_d   = 1'b0;
                            rf_addr_d = '0;
                            rf_din_d  = '0;
                        end
                        default: ;
                    endcase
                end
            end
            ST_WRITE: begin
                rf_we_d = 1'b1;
`ifdef REGFILE_WR_VERIFY_EN
                state_d = ST_VERIFY;
`else
                state_d = ST_IDLE;
`endif
            end
`ifdef REGFILE_WR_VERIFY_EN
            ST_VERIFY: begin
                // rf_din still holds the written word, so it serves as the saved wdata
                if (rf_dout != rf_din_q) wr_err_d = 1'b1;
                state_d = ST_IDLE;
            end
`endif
            ST_READ: begin
                rsp_rdata_d = rf_dout;
                rsp_valid_d = 1'b1;
                state_d     = ST_RESP;
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_CLEAR;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= ST_CLEAR;
            clr_ptr_q   <= '0;
            rf_we_q     <= 1'b1;
            rf_addr_q   <= '0;
            rf_din_q    <= '0;
            rsp_valid_q <= 1'b0;
            rsp_rdata_q <= '0;
`ifdef REGFILE_WR_VERIFY_EN
            wr_err_q    <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            clr_ptr_q   <= clr_ptr_d;
            rf_we_q     <= rf_we_d;
            rf_addr_q   <= rf_addr_d;
            rf_din_q    <= rf_din_d;
            rsp_valid_q <= rsp_valid_d;
            rsp_rdata_q <= rsp_rdata_d;
`ifdef REGFILE_WR_VERIFY_EN
            wr_err_q    <= wr_err_d;
`endif
        end
    end

    assign cmd_ready = (state_q == ST_IDLE);
    assign busy      = (state_q != ST_IDLE);
    assign rf_we_    = rf_we_q;
    assign rf_addr   = rf_addr_q;
    assign rf_din    = rf_din_q;
    assign rsp_valid = rsp_valid_q;
    assign rsp_rdata = rsp_rdata_q;
`ifdef REGFILE_WR_VERIFY_EN
    assign wr_err    = wr_err_q;
`else
    assign wr_err    = 1'b0;
`endif

endmodule

// File: tb/tb_regfile_master.sv
// Randomized bench for regfile_master: behavioural regfile plus a command-level memory reference.
// The stuck-bit write-verify phase runs only when REGFILE_WR_VERIFY_EN is defined.
module tb_regfile_master;
    import regfile_master_pkg::*;

    localparam int DW    = DATA_W_DEF;
    localparam int AW    = ADDR_W_DEF;
    localparam int DEPTH = 1 << AW;

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic          cmd_valid = 1'b0;
    logic [1:0]    cmd_op = 2'b00;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_ready = 1'b0;
    logic          cmd_ready, rsp_valid, busy, wr_err, rf_we_;
    logic [DW-1:0] rsp_rdata, rf_din, rf_dout;
    logic [AW-1:0] rf_addr;

    logic [DW-1:0] mem [DEPTH];
    logic [DW-1:0] ref_mem [DEPTH];
    logic          scramble = 1'b0;
    logic          stuck_en = 1'b0;
    logic          exp_err = 1'b0;
    int            total = 0;
    int            bad = 0;

    regfile_master #(.DATA_W(DW), .ADDR_W(AW)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .busy(busy), .wr_err(wr_err),
        .rf_we_(rf_we_), .rf_addr(rf_addr), .rf_din(rf_din), .rf_dout(rf_dout)
    );

    always #5 clk = ~clk;

    // Regfile model: garbage contents on scramble so the clear sweep is observable.
    always @(posedge clk) begin
        if (scramble) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= $urandom;
        end else if (!rf_we_) begin
            mem[rf_addr] <= rf_din;
        end
    end
    assign rf_dout = stuck_en ? {mem[rf_addr][DW-1:1], 1'b0} : mem[rf_addr];

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic do_cmd(input logic [1:0] op, input logic [AW-1:0] a, input logic [DW-1:0] d);
        int n = 0;
        while (!cmd_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("cmd_ready_wait", cmd_ready, 1);
        if (!cmd_ready) return;
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = a;
        cmd_wdata = d;
        @(negedge clk);
        cmd_valid = 1'b0;
        cmd_addr  = AW'($urandom);
        cmd_wdata = $urandom;
    endtask

    // Entered at the negedge right after sweep edge 1.
    task automatic check_sweep();
        for (int k = 0; k < DEPTH; k++) begin
            if (k > 0) @(negedge clk);
            chk("swp_we", rf_we_, 0);
            chk("swp_addr", rf_addr, k);
            chk("swp_din", rf_din, 0);
            chk("swp_rdy", cmd_ready, 0);
            chk("swp_busy", busy, 1);
        end
        @(negedge clk);
        chk("swp_end_we", rf_we_, 1);
        chk("swp_end_rdy", cmd_ready, 1);
        chk("swp_end_busy", busy, 0);
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = '0;
    endtask

    task automatic do_reset();
        reset    = 1'b1;
        scramble = 1'b1;
        @(negedge clk);
        scramble = 1'b0;
        chk("rst_rdy", cmd_ready, 0);
        chk("rst_busy", busy, 1);
        chk("rst_we", rf_we_, 1);
        chk("rst_addr", rf_addr, 0);
        chk("rst_din", rf_din, 0);
        chk("rst_vld", rsp_valid, 0);
        chk("rst_rdata", rsp_rdata, 0);
        chk("rst_err", wr_err, 0);
        exp_err = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        check_sweep();
    endtask

    task automatic do_write(input logic [AW-1:0] a, input logic [DW-1:0] d);
        do_cmd(OP_WR, a, d);
        chk("wr_we", rf_we_, 0);
        chk("wr_addr", rf_addr, a);
        chk("wr_din", rf_din, d);
        chk("wr_busy", busy, 1);
        @(negedge clk);
        chk("wr_we_e1", rf_we_, 1);
        ref_mem[a] = d;
`ifdef REGFILE_WR_VERIFY_EN
        chk("wr_rdy_e1", cmd_ready, 0);
        if (stuck_en && d[0]) exp_err = 1'b1;
        @(negedge clk);
`endif
        chk("wr_rdy", cmd_ready, 1);
        chk("wr_err", wr_err, exp_err);
    endtask

    task automatic do_read(input logic [AW-1:0] a, input int hold);
        logic [DW-1:0] exp_d;
        exp_d = ref_mem[a];
        rsp_ready = 1'b0;
        do_cmd(OP_RD, a, $urandom);
        chk("rd_vld_e0", rsp_valid, 0);
        chk("rd_we_e0", rf_we_, 1);
        chk("rd_addr", rf_addr, a);
        @(negedge clk);
        chk("rd_vld", rsp_valid, 1);
        chk("rd_data", rsp_rdata, exp_d);
        for (int i = 0; i < hold; i++) begin
            cmd_valid = 1'b1;
            cmd_op    = OP_WR;
            cmd_addr  = AW'($urandom);
            @(negedge clk);
            chk("hold_vld", rsp_valid, 1);
            chk("hold_data", rsp_rdata, exp_d);
            chk("hold_rdy", cmd_ready, 0);
            chk("hold_we", rf_we_, 1);
        end
        cmd_valid = 1'b0;
        rsp_ready = 1'b1;
        @(negedge clk);
        chk("rd_done_vld", rsp_valid, 0);
        chk("rd_done_rdy", cmd_ready, 1);
        rsp_ready = 1'b0;
    endtask

    task automatic do_rsv();
        do_cmd(OP_RSV, AW'($urandom), $urandom);
        chk("rsv_rdy", cmd_ready, 1);
        chk("rsv_vld", rsp_valid, 0);
        chk("rsv_we", rf_we_, 1);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int r;
        @(negedge clk);
        do_reset();
        do_read(AW'(31), 0);
        do_write(AW'(5), 32'hDEAD_BEEF);
        do_read(AW'(5), 0);
        do_read(AW'(5), 4);
        do_write(AW'(3), 32'h1);
        do_read(AW'(3), 0);
        do_cmd(OP_CLR, '0, '0);
        check_sweep();
        do_read(AW'(3), 0);
        do_rsv();
        @(negedge clk);
        chk("rsv_vld_later", rsp_valid, 0);

        // Reset while a response is pending
        do_write(AW'(9), 32'h1234_5678);
        rsp_ready = 1'b0;
        do_cmd(OP_RD, AW'(9), '0);
        @(negedge clk);
        chk("rresp_vld", rsp_valid, 1);
        do_reset();

        // Reset in the middle of a clear sweep
        do_cmd(OP_CLR, '0, '0);
        repeat (17) @(negedge clk);
        chk("mid_swp_addr", rf_addr, 17);
        do_reset();

        for (int n = 0; n < 80; n++) begin
            r = $urandom_range(0, 15);
            if (r < 7) begin
                do_write(AW'($urandom), $urandom);
            end else if (r < 14) begin
                do_read(AW'($urandom), $urandom_range(0, 3));
            end else if (r == 14) begin
                do_rsv();
            end else begin
                do_cmd(OP_CLR, '0, '0);
                check_sweep();
            end
        end

`ifdef REGFILE_WR_VERIFY_EN
        stuck_en = 1'b1;
        do_write(AW'(7), 32'h1);
        chk("vfy_err_set", wr_err, 1);
        do_write(AW'(8), 32'h2);
        do_write(AW'(9), 32'h10);
        chk("vfy_err_sticky", wr_err, 1);
        stuck_en = 1'b0;
        do_reset();
        chk("vfy_err_clr", wr_err, 0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
